// File: rtl/pipe_stage_reg_if.sv
// Valid/ready payload channel shared by the upstream and downstream sides
// of pipe_stage_reg.
interface pipe_stage_reg_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic [WIDTH-1:0] data;
  logic             ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Elastic DEPTH-stage pipeline register with per-stage valid bits and bubble collapse.
// Optional statistics counters are enabled by defining PIPE_STATS_EN.
module pipe_stage_reg #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 16,
  localparam int              OCC_W     = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  pipe_stage_reg_if.slave   up,
  pipe_stage_reg_if.master  dn,
  input  logic              flush,
  output logic [OCC_W-1:0]  occupancy
`ifdef PIPE_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] vld_nxt;
  logic [WIDTH-1:0] dat     [DEPTH];
  logic [WIDTH-1:0] dat_nxt [DEPTH];
  logic [DEPTH:0]   rdy;
  logic             in_rdy;

  function automatic logic [OCC_W-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [OCC_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + OCC_W'(v[i]);
    end
    return cnt;
  endfunction

  // Ready chain: a stage accepts when it is empty or its own beat moves on.
  always_comb begin : ready_chain
    logic chain;
    chain      = dn.ready;
    rdy[DEPTH] = dn.ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      chain  = ~vld[i] | chain;
      rdy[i] = chain;
    end
    in_rdy = rdy[0] & ~flush & ~RST;
  end

  // Next-state: load on transfer, empty on send-only, flush squashes everything.
  always_comb begin
    vld_nxt = vld;
    for (int i = 0; i < DEPTH; i++) begin
      dat_nxt[i] = dat[i];
    end
    if (flush) begin
      vld_nxt = '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat_nxt[i] = RESET_VAL;
      end
    end else begin
      if (up.valid & in_rdy) begin
        vld_nxt[0] = 1'b1;
        dat_nxt[0] = up.data;
      end else if (vld[0] & rdy[1]) begin
        vld_nxt[0] = 1'b0;
      end else begin
        vld_nxt[0] = vld[0];
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (vld[i-1] & rdy[i]) begin
          vld_nxt[i] = 1'b1;
          dat_nxt[i] = dat[i-1];
        end else if (vld[i] & rdy[i+1]) begin
          vld_nxt[i] = 1'b0;
        end else begin
          vld_nxt[i] = vld[i];
        end
      end
    end
  end

  // Stage registers and registered occupancy.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld       <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat[i] <= RESET_VAL;
      end
    end else begin
      vld       <= vld_nxt;
      occupancy <= popcount(vld_nxt);
      for (int i = 0; i < DEPTH; i++) begin
        dat[i] <= dat_nxt[i];
      end
    end
  end

  assign up.ready = in_rdy;
  assign dn.valid = vld[DEPTH-1];
  assign dn.data  = dat[DEPTH-1];

`ifdef PIPE_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating stall and flush counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (vld[DEPTH-1] & ~dn.ready & (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end else begin
        stall_cnt <= stall_cnt;
      end
      if (flush & (occupancy != '0) & (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end else begin
        flush_cnt <= flush_cnt;
      end
    end
  end
`endif

endmodule
